// File: rtl/multicycle_ctrl_pkg.sv
// Shared RV32I opcode constants, FSM state encoding and datapath select codes
// for the multicycle control unit.
package multicycle_ctrl_pkg;

  localparam logic [6:0] OP_R      = 7'h33;
  localparam logic [6:0] OP_I      = 7'h13;
  localparam logic [6:0] OP_LOAD   = 7'h03;
  localparam logic [6:0] OP_STORE  = 7'h23;
  localparam logic [6:0] OP_BRANCH = 7'h63;
  localparam logic [6:0] OP_LUI    = 7'h37;
  localparam logic [6:0] OP_AUIPC  = 7'h17;
  localparam logic [6:0] OP_JAL    = 7'h6F;
  localparam logic [6:0] OP_JALR   = 7'h67;
  localparam logic [6:0] OP_SYSTEM = 7'h73;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
  } state_t;

  localparam logic [1:0] PC_SEQ = 2'd0;  // pc+4
  localparam logic [1:0] PC_REL = 2'd1;  // pc+imm32
  localparam logic [1:0] PC_IND = 2'd2;  // (rs1+imm32)&~1

  localparam logic [1:0] WB_ALU = 2'd0;
  localparam logic [1:0] WB_MEM = 2'd1;
  localparam logic [1:0] WB_PC4 = 2'd2;
  localparam logic [1:0] WB_IMM = 2'd3;

  typedef struct packed {
    logic       imem_req;
    logic       ir_we;
    logic       dmem_req;
    logic       dmem_we;
    logic       alu_a_sel;
    logic       alu_b_sel;
    logic       pc_we;
    logic [1:0] pc_sel;
    logic       rf_we;
    logic [1:0] wb_sel;
  } ctrl_t;

  function automatic logic op_legal(input logic [6:0] op);
    case (op)
      OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH, OP_LUI,
      OP_AUIPC, OP_JAL, OP_JALR, OP_SYSTEM: return 1'b1;
      default:                              return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Datapath/memory-facing signal bundle of the multicycle control unit.
// master = control unit, slave = datapath and memory side.
interface multicycle_ctrl_if;
  logic [6:0]  opcode;
  logic        branch_taken;
  logic        imem_ready;
  logic        dmem_ready;
  logic        imem_req;
  logic        ir_we;
  logic        dmem_req;
  logic        dmem_we;
  logic        alu_a_sel;
  logic        alu_b_sel;
  logic        pc_we;
  logic [1:0]  pc_sel;
  logic        rf_we;
  logic [1:0]  wb_sel;
  logic        halted;
  logic        illegal;
  logic        bus_err;
  logic [31:0] instret;

  modport master (
    input  opcode, branch_taken, imem_ready, dmem_ready,
    output imem_req, ir_we, dmem_req, dmem_we, alu_a_sel, alu_b_sel,
           pc_we, pc_sel, rf_we, wb_sel, halted, illegal, bus_err, instret
  );

  modport slave (
    output opcode, branch_taken, imem_ready, dmem_ready,
    input  imem_req, ir_we, dmem_req, dmem_we, alu_a_sel, alu_b_sel,
           pc_we, pc_sel, rf_we, wb_sel, halted, illegal, bus_err, instret
  );
endinterface

// File: rtl/multicycle_ctrl.sv
// RV32I multicycle sequencer: fetch/decode/exec/mem/wb FSM, memory handshakes,
// bus watchdog and retired-instruction counter.
module multicycle_ctrl
  import multicycle_ctrl_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input logic               clk,
  input logic               rst_n,
  multicycle_ctrl_if.master bus
);

  localparam logic [15:0] WAIT_LAST = 16'(MEM_TIMEOUT - 1);

  state_t      state;
  logic [6:0]  op_q;
  logic [15:0] wait_cnt;
  logic [31:0] instret_q;
  logic        halted_q, illegal_q, bus_err_q;
  ctrl_t       c;
  logic        req_wait, timeout;

  // A request waiting on its last allowed cycle times out; ready that cycle wins.
  assign req_wait = (state == S_FETCH && !bus.imem_ready) ||
                    (state == S_MEM   && !bus.dmem_ready);
  assign timeout  = req_wait && (wait_cnt == WAIT_LAST);

  // Strobes depend on same-cycle ready/branch inputs, so they stay combinational.
  always_comb begin
    c = '0;
    case (state)
      S_FETCH: begin
        c.imem_req = 1'b1;
        c.ir_we    = bus.imem_ready;
      end
      S_EXEC: begin
        case (op_q)
          OP_I, OP_LOAD, OP_STORE, OP_JALR: c.alu_b_sel = 1'b1;
          OP_AUIPC, OP_JAL: begin
            c.alu_a_sel = 1'b1;
            c.alu_b_sel = 1'b1;
          end
          OP_BRANCH: begin
            c.pc_we  = 1'b1;
            c.pc_sel = bus.branch_taken ? PC_REL : PC_SEQ;
          end
          default: ;
        endcase
      end
      S_MEM: begin
        c.dmem_req = 1'b1;
        c.dmem_we  = (op_q == OP_STORE);
        c.pc_we    = (op_q == OP_STORE) && bus.dmem_ready;
      end
      S_WB: begin
        c.rf_we = 1'b1;
        c.pc_we = 1'b1;
        case (op_q)
          OP_LOAD:         c.wb_sel = WB_MEM;
          OP_JAL, OP_JALR: c.wb_sel = WB_PC4;
          OP_LUI:          c.wb_sel = WB_IMM;
          default:         c.wb_sel = WB_ALU;
        endcase
        case (op_q)
          OP_JAL:  c.pc_sel = PC_REL;
          OP_JALR: c.pc_sel = PC_IND;
          default: c.pc_sel = PC_SEQ;
        endcase
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      op_q      <= '0;
      wait_cnt  <= '0;
      instret_q <= '0;
      halted_q  <= 1'b0;
      illegal_q <= 1'b0;
      bus_err_q <= 1'b0;
    end else begin
      instret_q <= instret_q + 32'(c.pc_we);
      if (req_wait) wait_cnt <= wait_cnt + 16'd1;
      if (timeout) begin
        state     <= S_HALT;
        halted_q  <= 1'b1;
        bus_err_q <= 1'b1;
      end else begin
        case (state)
          S_IDLE: begin
            state    <= S_FETCH;
            wait_cnt <= '0;
          end
          S_FETCH: if (bus.imem_ready) state <= S_DECODE;
          S_DECODE: begin
            op_q <= bus.opcode;
            if (bus.opcode == OP_SYSTEM) begin
              state    <= S_HALT;
              halted_q <= 1'b1;
            end else if (!op_legal(bus.opcode)) begin
              state     <= S_HALT;
              halted_q  <= 1'b1;
              illegal_q <= 1'b1;
            end else begin
              state <= S_EXEC;
            end
          end
          S_EXEC: begin
            if (op_q == OP_LOAD || op_q == OP_STORE) begin
              state    <= S_MEM;
              wait_cnt <= '0;
            end else if (op_q == OP_BRANCH) begin
              state    <= S_FETCH;
              wait_cnt <= '0;
            end else begin
              state <= S_WB;
            end
          end
          S_MEM: begin
            if (bus.dmem_ready) begin
              if (op_q == OP_STORE) begin
                state    <= S_FETCH;
                wait_cnt <= '0;
              end else begin
                state <= S_WB;
              end
            end
          end
          S_WB: begin
            state    <= S_FETCH;
            wait_cnt <= '0;
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.imem_req  = c.imem_req;
  assign bus.ir_we     = c.ir_we;
  assign bus.dmem_req  = c.dmem_req;
  assign bus.dmem_we   = c.dmem_we;
  assign bus.alu_a_sel = c.alu_a_sel;
  assign bus.alu_b_sel = c.alu_b_sel;
  assign bus.pc_we     = c.pc_we;
  assign bus.pc_sel    = c.pc_sel;
  assign bus.rf_we     = c.rf_we;
  assign bus.wb_sel    = c.wb_sel;
  assign bus.halted    = halted_q;
  assign bus.illegal   = illegal_q;
  assign bus.bus_err   = bus_err_q;
  assign bus.instret   = instret_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Randomized instruction-stream bench for multicycle_ctrl; expected per-cycle
// strobes come from an instruction-level timeline model.
module tb_multicycle_ctrl;

  localparam int TMO = 4;

  localparam logic [6:0] R = 7'h33, I = 7'h13, LD = 7'h03, ST = 7'h23, BR = 7'h63;
  localparam logic [6:0] LUI = 7'h37, AUIPC = 7'h17, JAL = 7'h6F, JALR = 7'h67, SYS = 7'h73;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  multicycle_ctrl_if bus();
  multicycle_ctrl #(.MEM_TIMEOUT(TMO)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int          n_tests = 0;
  int          n_fail  = 0;
  int unsigned cnt     = 0;
  bit          x_halt, x_ill, x_berr;
  logic [6:0]  ops [9] = '{R, I, LD, ST, BR, LUI, AUIPC, JAL, JALR};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // {imem_req, ir_we, dmem_req, dmem_we, a_sel, b_sel, pc_we, pc_sel[1:0], rf_we, wb_sel[1:0]}
  function automatic logic [11:0] mk(input bit im, ir, dq, dw, a, b, pw,
                                     input logic [1:0] ps, input bit rf,
                                     input logic [1:0] ws);
    return {im, ir, dq, dw, a, b, pw, ps, rf, ws};
  endfunction

  function automatic logic [11:0] strobes();
    return {bus.imem_req, bus.ir_we, bus.dmem_req, bus.dmem_we, bus.alu_a_sel,
            bus.alu_b_sel, bus.pc_we, bus.pc_sel, bus.rf_we, bus.wb_sel};
  endfunction

  function automatic bit legal(input logic [6:0] op);
    return op inside {R, I, LD, ST, BR, LUI, AUIPC, JAL, JALR, SYS};
  endfunction

  task automatic cyc(input string tag, input bit ir, input bit dr, input bit bt,
                     input logic [6:0] op, input logic [11:0] e);
    @(negedge clk);
    bus.imem_ready   = ir;
    bus.dmem_ready   = dr;
    bus.branch_taken = bt;
    bus.opcode       = op;
    #1;
    chk({tag, " strobes"}, 32'(strobes()), 32'(e));
    chk({tag, " flags"}, 32'({bus.halted, bus.illegal, bus.bus_err}),
        32'({x_halt, x_ill, x_berr}));
    chk({tag, " instret"}, bus.instret, cnt);
    if (e[5]) cnt++;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    x_halt = 0; x_ill = 0; x_berr = 0; cnt = 0;
    chk("rst strobes", 32'(strobes()), 32'd0);
    chk("rst flags", 32'({bus.halted, bus.illegal, bus.bus_err}), 32'd0);
    chk("rst instret", bus.instret, 32'd0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    bus.imem_ready = 1'b1;
    bus.dmem_ready = 1'b1;
    #1;
    chk("idle strobes", 32'(strobes()), 32'd0);
  endtask

  task automatic halt_hold(input int n);
    repeat (n) cyc("halt", 1'($urandom), 1'($urandom), 1'($urandom), 7'($urandom), 12'd0);
  endtask

  // One instruction: iw/dw = ready wait cycles, abort_mem = stop after first MEM cycle.
  task automatic run_instr(input logic [6:0] op, input int iw, input int dw,
                           input bit bt, input bit abort_mem);
    bit a, b, st, rdy;
    logic [1:0] ps, ws;
    for (int k = 0; ; k++) begin
      rdy = (k == iw);
      cyc("fetch", rdy, 1'($urandom), 1'($urandom), 7'($urandom),
          mk(1, rdy, 0, 0, 0, 0, 0, 2'd0, 0, 2'd0));
      if (rdy) break;
      if (k == TMO - 1) begin x_halt = 1; x_berr = 1; return; end
    end
    cyc("decode", 1'($urandom), 1'($urandom), 1'($urandom), op, 12'd0);
    if (op == SYS) begin x_halt = 1; return; end
    if (!legal(op)) begin x_halt = 1; x_ill = 1; return; end
    if (op == BR) begin
      cyc("exec br", 1'($urandom), 1'($urandom), bt, op,
          mk(0, 0, 0, 0, 0, 0, 1, {1'b0, bt}, 0, 2'd0));
      return;
    end
    a = op inside {AUIPC, JAL};
    b = op inside {I, LD, ST, JALR, AUIPC, JAL};
    cyc("exec", 1'($urandom), 1'($urandom), 1'($urandom), op,
        mk(0, 0, 0, 0, a, b, 0, 2'd0, 0, 2'd0));
    if (op == LD || op == ST) begin
      st = (op == ST);
      for (int k = 0; ; k++) begin
        rdy = (k == dw);
        cyc("mem", 1'($urandom), rdy, 1'($urandom), op,
            mk(0, 0, 1, st, 0, 0, st & rdy, 2'd0, 0, 2'd0));
        if (abort_mem) return;
        if (rdy) break;
        if (k == TMO - 1) begin x_halt = 1; x_berr = 1; return; end
      end
      if (st) return;
    end
    ws = (op == LD) ? 2'd1 : (op == JAL || op == JALR) ? 2'd2 : (op == LUI) ? 2'd3 : 2'd0;
    ps = (op == JAL) ? 2'd1 : (op == JALR) ? 2'd2 : 2'd0;
    cyc("wb", 1'($urandom), 1'($urandom), 1'($urandom), op,
        mk(0, 0, 0, 0, 0, 0, 1, ps, 1, ws));
  endtask

  initial begin
    logic [6:0] bad;
    bus.opcode = '0; bus.branch_taken = 0; bus.imem_ready = 0; bus.dmem_ready = 0;
    do_reset();
    run_instr(R, 0, 0, 0, 0);
    run_instr(LD, 0, 3, 0, 0);
    run_instr(BR, 0, 0, 1, 0);
    run_instr(BR, 0, 0, 0, 0);
    for (int n = 0; n < 40; n++)
      run_instr(ops[$urandom_range(0, 8)], $urandom_range(0, TMO - 1),
                $urandom_range(0, TMO - 1), 1'($urandom), 0);
    // reset while a store request is outstanding
    run_instr(ST, 0, 2, 0, 1);
    do_reset();
    run_instr(I, TMO - 1, 0, 0, 0);
    run_instr(JALR, 0, 0, 0, 0);
    run_instr(I, TMO, 0, 0, 0);
    halt_hold(5);
    do_reset();
    run_instr(LD, 1, TMO, 0, 0);
    halt_hold(5);
    do_reset();
    run_instr(7'h7F, 0, 0, 0, 0);
    halt_hold(20);
    do_reset();
    bad = 7'($urandom);
    while (legal(bad)) bad = 7'($urandom);
    run_instr(AUIPC, 0, 0, 0, 0);
    run_instr(bad, 1, 0, 0, 0);
    halt_hold(3);
    do_reset();
    run_instr(LUI, 0, 0, 0, 0);
    run_instr(SYS, 0, 0, 0, 0);
    halt_hold(3);
    do_reset();
    run_instr(JAL, 2, 0, 0, 0);
    run_instr(ST, 0, 0, 0, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
